// File: rtl/noc_inj_sched_if.sv
// Injection-port bundle between local packet sources and the p0 scheduler.
// master = scheduler side, slave = sources/router side.
`ifndef DATAW_P1
`define DATAW_P1 32
`endif

interface noc_inj_sched_if #(
  parameter int NREQ  = 4,
  parameter int VCH   = 2,
  parameter int LENW  = 6,
  parameter int DSTW  = 4,
  parameter int DATAW = `DATAW_P1
);
  localparam int VCHW = (VCH > 1) ? $clog2(VCH) : 1;

  logic [NREQ-1:0]       req_i;
  logic [NREQ*DSTW-1:0]  dst_i;
  logic [NREQ*VCHW-1:0]  vch_i;
  logic [NREQ*LENW-1:0]  len_i;
  logic [NREQ*DATAW-1:0] data_i;
  logic [NREQ-1:0]       gnt_o;
  logic [NREQ-1:0]       data_pop_o;
  logic [NREQ-1:0]       done_o;
  logic [VCH-1:0]        ordy_i;
  logic [DATAW-1:0]      idata_o;
  logic                  ivalid_o;
  logic [VCHW-1:0]       ivch_o;

  modport master (
    input  req_i, dst_i, vch_i, len_i, data_i, ordy_i,
    output gnt_o, data_pop_o, done_o, idata_o, ivalid_o, ivch_o
  );

  modport slave (
    output req_i, dst_i, vch_i, len_i, data_i, ordy_i,
    input  gnt_o, data_pop_o, done_o, idata_o, ivalid_o, ivch_o
  );
endinterface

// File: rtl/noc_inj_sched.sv
// Round-robin injection scheduler for router p0; NOC_INJ_STATS_EN adds packet/flit counters.
// req->gnt 1 cycle, gnt->head >=1 cycle; head waits on ordy[vc], body flits never stall.
`ifndef DATAW_P1
`define DATAW_P1 32
`endif
`ifndef TYPE_DATA
`define TYPE_DATA 2'b00
`endif
`ifndef TYPE_HEAD
`define TYPE_HEAD 2'b01
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 2'b10
`endif
`ifndef TYPE_HEADTAIL
`define TYPE_HEADTAIL 2'b11
`endif

module noc_inj_sched #(
  parameter int NREQ   = 4,
  parameter int SRC_ID = 0,
  parameter int VCH    = 2,
  parameter int LENW   = 6,
  parameter int DSTW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  noc_inj_sched_if.master bus
`ifdef NOC_INJ_STATS_EN
  ,
  output logic [15:0]     pkt_cnt_o,
  output logic [15:0]     flit_cnt_o
`endif
);

  localparam int VCHW    = (VCH > 1) ? $clog2(VCH) : 1;
  localparam int IDXW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DATAW   = `DATAW_P1;
  localparam int TYPE_LO = DATAW - 2;
  // Head layout below TYPE: DST, SRC, then a 4-bit VC field.
  localparam int DST_LO  = TYPE_LO - DSTW;
  localparam int SRC_LO  = DST_LO - DSTW;
  localparam int VCH_LO  = SRC_LO - 4;
  localparam logic [DSTW-1:0]  SRC_L        = DSTW'(SRC_ID);
  localparam logic [DATAW-1:0] PAYLOAD_MASK = {2'b00, {TYPE_LO{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY} state_e;

  state_e            state_q;
  logic [IDXW-1:0]   ptr_q;
  logic [IDXW-1:0]   win_q;
  logic [DSTW-1:0]   dst_q;
  logic [VCHW-1:0]   vch_q;
  logic [LENW-1:0]   len_q;
  logic [LENW-1:0]   cnt_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   done_q;
  logic [DATAW-1:0]  idata_q;
  logic              ivalid_q;
  logic [VCHW-1:0]   ivch_q;

  logic [IDXW-1:0]   win_d;
  logic              win_found;
  logic [IDXW-1:0]   cand;
  int                idx;
  logic [LENW-1:0]   len_sel;
  logic [NREQ-1:0]   win_onehot;
  logic [IDXW-1:0]   ptr_d;
  logic [DATAW-1:0]  head_flit;
  logic [DATAW-1:0]  cur_data;
  logic [DATAW-1:0]  body_flit;
  logic              body_last;

  // Search starts at the RR pointer and wraps so every requester gets a turn.
  always_comb begin
    win_d     = '0;
    win_found = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDXW'(idx);
      if (!win_found && bus.req_i[cand]) begin
        win_found = 1'b1;
        win_d     = cand;
      end
    end
  end

  always_comb begin
    len_sel    = bus.len_i[win_d*LENW +: LENW];
    win_onehot = NREQ'(1) << win_d;
    ptr_d      = (win_q == IDXW'(NREQ-1)) ? '0 : win_q + 1'b1;
    body_last  = (cnt_q == len_q - 1'b1);

    head_flit                        = '0;
    head_flit[DATAW-1:TYPE_LO]       = (len_q == LENW'(1)) ? `TYPE_HEADTAIL : `TYPE_HEAD;
    head_flit[DST_LO +: DSTW]        = dst_q;
    head_flit[SRC_LO +: DSTW]        = SRC_L;
    head_flit[VCH_LO +: VCHW]        = vch_q;

    cur_data  = bus.data_i[win_q*DATAW +: DATAW];
    body_flit = (cur_data & PAYLOAD_MASK)
              | {(body_last ? `TYPE_TAIL : `TYPE_DATA), {TYPE_LO{1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      dst_q    <= '0;
      vch_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      idata_q  <= '0;
      ivalid_q <= 1'b0;
      ivch_q   <= '0;
    end else begin
      done_q   <= '0;
      idata_q  <= '0;
      ivalid_q <= 1'b0;
      ivch_q   <= '0;
      case (state_q)
        S_IDLE: begin
          if (|bus.req_i) begin
            win_q   <= win_d;
            dst_q   <= bus.dst_i[win_d*DSTW +: DSTW];
            vch_q   <= bus.vch_i[win_d*VCHW +: VCHW];
            len_q   <= (len_sel == '0) ? LENW'(1) : len_sel;
            gnt_q   <= win_onehot;
            state_q <= S_HEAD;
          end
        end
        S_HEAD: begin
          if (bus.ordy_i[vch_q]) begin
            ivalid_q <= 1'b1;
            idata_q  <= head_flit;
            ivch_q   <= vch_q;
            cnt_q    <= LENW'(1);
            if (len_q == LENW'(1)) begin
              done_q  <= gnt_q;
              gnt_q   <= '0;
              ptr_q   <= ptr_d;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_BODY;
            end
          end
        end
        S_BODY: begin
          // Packet-level flow control: once the head is out, ordy is not consulted.
          ivalid_q <= 1'b1;
          idata_q  <= body_flit;
          ivch_q   <= vch_q;
          cnt_q    <= cnt_q + 1'b1;
          if (body_last) begin
            done_q  <= gnt_q;
            gnt_q   <= '0;
            ptr_q   <= ptr_d;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt_o      = gnt_q;
  assign bus.done_o     = done_q;
  assign bus.idata_o    = idata_q;
  assign bus.ivalid_o   = ivalid_q;
  assign bus.ivch_o     = ivch_q;
  assign bus.data_pop_o = (state_q == S_BODY) ? gnt_q : '0;

`ifdef NOC_INJ_STATS_EN
  logic [15:0] pkt_cnt_q;
  logic [15:0] flit_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q  <= '0;
      flit_cnt_q <= '0;
    end else begin
      if (|done_q && pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (ivalid_q && flit_cnt_q != 16'hFFFF) flit_cnt_q <= flit_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt_o  = pkt_cnt_q;
  assign flit_cnt_o = flit_cnt_q;
`else
`endif

endmodule

// File: tb/tb_noc_inj_sched.sv
// Bench for noc_inj_sched: table of directed packets, reset-mid-packet sequence,
// then random packets checked against a transaction-level model.
`ifndef DATAW_P1
`define DATAW_P1 32
`endif
`ifndef TYPE_DATA
`define TYPE_DATA 2'b00
`endif
`ifndef TYPE_HEAD
`define TYPE_HEAD 2'b01
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 2'b10
`endif
`ifndef TYPE_HEADTAIL
`define TYPE_HEADTAIL 2'b11
`endif

module tb_noc_inj_sched;
  localparam int NREQ = 4, VCH = 2, LENW = 6, DSTW = 4, SRC_ID = 5;
  localparam int DW = `DATAW_P1;
  localparam int VCHW = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  noc_inj_sched_if #(.NREQ(NREQ), .VCH(VCH), .LENW(LENW), .DSTW(DSTW)) bus ();

`ifdef NOC_INJ_STATS_EN
  logic [15:0] pkt_cnt, flit_cnt;
`endif

  noc_inj_sched #(.NREQ(NREQ), .SRC_ID(SRC_ID), .VCH(VCH), .LENW(LENW), .DSTW(DSTW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef NOC_INJ_STATS_EN
    ,
    .pkt_cnt_o(pkt_cnt),
    .flit_cnt_o(flit_cnt)
`endif
  );

  typedef struct {
    logic [NREQ-1:0] req;
    logic [DSTW-1:0] dst;
    logic [VCHW-1:0] vch;
    logic [LENW-1:0] len;
    int              ordy_low;
    bit              drop;
    int              exp_win;
  } vec_t;

  int vec_cnt = 0;
  int err_cnt = 0;
  int mptr = 0;
  int pkts = 0;
  int flits = 0;
  logic [DSTW-1:0] s_dst[NREQ];
  logic [VCHW-1:0] s_vch[NREQ];
  logic [LENW-1:0] s_len[NREQ];
  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_fields();
    for (int r = 0; r < NREQ; r++) begin
      bus.dst_i[r*DSTW +: DSTW] = s_dst[r];
      bus.vch_i[r*VCHW +: VCHW] = s_vch[r];
      bus.len_i[r*LENW +: LENW] = s_len[r];
    end
  endtask

  task automatic rand_data();
    for (int r = 0; r < NREQ; r++) bus.data_i[r*DW +: DW] = $urandom;
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] req);
    for (int k = 0; k < NREQ; k++)
      if (req[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
    return 0;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"}, 64'(bus.gnt_o), 64'd0);
    check({tag, "_done"}, 64'(bus.done_o), 64'd0);
    check({tag, "_ivalid"}, 64'(bus.ivalid_o), 64'd0);
    check({tag, "_idata"}, 64'(bus.idata_o), 64'd0);
    check({tag, "_ivch"}, 64'(bus.ivch_o), 64'd0);
    check({tag, "_pop"}, 64'(bus.data_pop_o), 64'd0);
  endtask

  // Called on a negedge; returns on the negedge at which the tail is visible.
  task automatic do_packet(input logic [NREQ-1:0] req, input int ordy_low, input bit drop_mid,
                           input int exp_win);
    int w, len;
    logic [NREQ-1:0] oh;
    logic [DSTW-1:0] e_dst;
    logic [VCHW-1:0] e_vch;
    logic [VCH-1:0]  o;
    logic [DW-1:0]   expd, dv;
    logic [1:0]      typ;
    w     = (exp_win >= 0) ? exp_win : model_pick(req);
    oh    = NREQ'(1) << w;
    e_dst = s_dst[w];
    e_vch = s_vch[w];
    len   = (s_len[w] == 0) ? 1 : int'(s_len[w]);
    bus.req_i = req;
    drive_fields();
    rand_data();
    o = VCH'($urandom);
    o[e_vch] = (ordy_low == 0);
    bus.ordy_i = o;

    @(negedge clk);
    check("gnt_latch", 64'(bus.gnt_o), 64'(oh));
    check("idle_gap", 64'(bus.ivalid_o), 64'd0);
    // Everything after the latch must be ignored by the scheduler.
    for (int r = 0; r < NREQ; r++) begin
      s_dst[r] = DSTW'($urandom);
      s_vch[r] = VCHW'($urandom);
      s_len[r] = LENW'($urandom);
    end
    drive_fields();
    bus.req_i = NREQ'($urandom);

    for (int c = 0; c < ordy_low; c++) begin
      @(negedge clk);
      check("ordy_hold_ivalid", 64'(bus.ivalid_o), 64'd0);
      check("ordy_hold_gnt", 64'(bus.gnt_o), 64'(oh));
    end
    bus.ordy_i[e_vch] = 1'b1;

    @(negedge clk);
    typ  = (len == 1) ? `TYPE_HEADTAIL : `TYPE_HEAD;
    expd = (DW'(typ) << (DW-2)) | (DW'(e_dst) << (DW-2-DSTW)) | (DW'(SRC_ID) << (DW-2-2*DSTW))
         | (DW'(e_vch) << (DW-6-2*DSTW));
    check("head_valid", 64'(bus.ivalid_o), 64'd1);
    check("head_flit", 64'(bus.idata_o), 64'(expd));
    check("head_vch", 64'(bus.ivch_o), 64'(e_vch));
    check("head_done", 64'(bus.done_o), (len == 1) ? 64'(oh) : 64'd0);
    check("head_gnt", 64'(bus.gnt_o), (len == 1) ? 64'd0 : 64'(oh));

    for (int k = 1; k < len; k++) begin
      check("body_pop", 64'(bus.data_pop_o), 64'(oh));
      if (drop_mid && k == 1) bus.ordy_i = '0;
      rand_data();
      dv   = bus.data_i[w*DW +: DW];
      typ  = (k == len - 1) ? `TYPE_TAIL : `TYPE_DATA;
      expd = (dv & 32'h3FFF_FFFF) | (DW'(typ) << (DW-2));
      @(negedge clk);
      check("body_valid", 64'(bus.ivalid_o), 64'd1);
      check("body_flit", 64'(bus.idata_o), 64'(expd));
      check("body_vch", 64'(bus.ivch_o), 64'(e_vch));
      check("body_done", 64'(bus.done_o), (k == len - 1) ? 64'(oh) : 64'd0);
    end
    check("tail_gnt_clr", 64'(bus.gnt_o), 64'd0);
    check("tail_pop_clr", 64'(bus.data_pop_o), 64'd0);
    mptr = (w + 1) % NREQ;
    pkts++;
    flits += len;
    bus.req_i = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{4'b1111, 4'd4, 1'b0, 6'd2,  0,  1'b0, 0};
    tbl[1]  = '{4'b1111, 4'd4, 1'b0, 6'd2,  0,  1'b0, 1};
    tbl[2]  = '{4'b1111, 4'd4, 1'b0, 6'd2,  0,  1'b0, 2};
    tbl[3]  = '{4'b1111, 4'd4, 1'b0, 6'd2,  0,  1'b0, 3};
    tbl[4]  = '{4'b1111, 4'd4, 1'b0, 6'd2,  0,  1'b0, 0};
    tbl[5]  = '{4'b0001, 4'd4, 1'b0, 6'd5,  0,  1'b0, 0};
    tbl[6]  = '{4'b0010, 4'd9, 1'b1, 6'd1,  0,  1'b0, 1};
    tbl[7]  = '{4'b0010, 4'd2, 1'b0, 6'd0,  0,  1'b0, 1};
    tbl[8]  = '{4'b0100, 4'd7, 1'b1, 6'd4,  10, 1'b1, 2};
    tbl[9]  = '{4'b1001, 4'd3, 1'b0, 6'd3,  0,  1'b0, 3};
    tbl[10] = '{4'b1001, 4'd3, 1'b1, 6'd3,  2,  1'b0, 0};
    tbl[11] = '{4'b0110, 4'd15, 1'b1, 6'd63, 0, 1'b1, 1};

    rst = 1'b1;
    bus.req_i = '0; bus.dst_i = '0; bus.vch_i = '0; bus.len_i = '0;
    bus.data_i = '0; bus.ordy_i = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    mptr = 0;

    for (int i = 0; i < 12; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        s_dst[r] = tbl[i].dst + DSTW'(r);
        s_vch[r] = tbl[i].vch;
        s_len[r] = tbl[i].len;
      end
      do_packet(tbl[i].req, tbl[i].ordy_low, tbl[i].drop, tbl[i].exp_win);
    end
    @(negedge clk);
    check("post_table_idle", 64'(bus.ivalid_o), 64'd0);
`ifdef NOC_INJ_STATS_EN
    check("stats_pkt", 64'(pkt_cnt), 64'(pkts));
    check("stats_flit", 64'(flit_cnt), 64'(flits));
`endif

    // Reset while flit 3 of a 6-flit packet would be registered.
    for (int r = 0; r < NREQ; r++) begin
      s_dst[r] = 4'd1; s_vch[r] = 1'b0; s_len[r] = 6'd6;
    end
    drive_fields();
    bus.ordy_i = 2'b11;
    bus.req_i  = 4'b0001;
    @(negedge clk);
    check("t5_gnt", 64'(bus.gnt_o), 64'd1);
    @(negedge clk);
    check("t5_head", 64'(bus.ivalid_o), 64'd1);
    @(negedge clk);
    check("t5_flit2", 64'(bus.ivalid_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("t5_rst");
`ifdef NOC_INJ_STATS_EN
    check("t5_stats_pkt", 64'(pkt_cnt), 64'd0);
    check("t5_stats_flit", 64'(flit_cnt), 64'd0);
`endif
    rst = 1'b0;
    mptr = 0;
    s_len[0] = 6'd2; s_len[1] = 6'd2;
    do_packet(4'b0011, 0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        s_dst[r] = DSTW'($urandom);
        s_vch[r] = VCHW'($urandom);
        s_len[r] = LENW'($urandom_range(0, 8));
      end
      do_packet(NREQ'($urandom_range(1, 15)), $urandom_range(0, 3), 1'($urandom), -1);
    end
    @(negedge clk);
    check("final_idle", 64'(bus.ivalid_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
